sfp_link_supervisor: RTL
========================

# sfp_link_supervisor

Link bring-up and recovery controller for the 10G SFP port. It runs on the free-running 125 MHz clock and watches GT reset-done, PCS block lock, high-BER and module presence. It sequences RX datapath resets, and escalates to a full GT reset after repeated lock failures. It also publishes a debounced link-up flag, a state code and a saturating link-flap counter for the status register.

## Interface
Parameters:
- RX_RESET_CYCLES, 32: width of an `rx_datapath_reset` pulse, in clk cycles.
- FULL_RESET_CYCLES, 256: width of a `gt_reset_all` pulse.
- LOCK_TIMEOUT, 125000: cycles allowed in WAIT_LOCK (1 ms).
- DONE_TIMEOUT, 250000: cycles allowed in WAIT_RX_DONE (2 ms).
- UP_DEBOUNCE, 1024: cycles of continuous lock with no high BER required before link-up.
- MAX_RX_RETRIES, 4: consecutive failed RX resets before escalating to a full reset.

Ports:
- `clk_125mhz_int`, in, 1: free-running clock.
- `gt_tx_reset`, in, 1: reset, asynchronous, active-high.
- `gt_reset_rx_done`, in, 1: asynchronous input, from the RX user-clock domain.
- `rx_block_lock`, in, 1: asynchronous input, PCS block lock.
- `rx_high_ber`, in, 1: asynchronous input, PCS high-BER indication.
- `sfp_modprs_n`, in, 1: asynchronous input; low means a module is present.
- `rx_datapath_reset`, out, 1: request to the GT RX datapath reset.
- `gt_reset_all`, out, 1: request for a full GT reset.
- `link_up`, out, 1: debounced link status.
- `link_state`, out, 3: current FSM state code.
- `flap_count`, out, 8: count of link-up to link-down transitions, saturating.

## Operation
- All four asynchronous inputs pass through a 2-flop synchronizer before use.
- All outputs are registered. A free-running `timer` counter is cleared on every state entry.
- `retry` is a 3-bit counter. `flap_count` is 8 bits and saturates at 255.

FSM states (`link_state` code in brackets):
- **NO_MODULE [0]**
  - Outputs: `rx_datapath_reset`=1.
  - Transition: `modprs_n`=0 → RX_RESET.
- **RX_RESET [1]**
  - Outputs: `rx_datapath_reset`=1 for RX_RESET_CYCLES.
  - Transition: then → WAIT_RX_DONE.
- **WAIT_RX_DONE [2]**
  - Transition: `rx_done` → WAIT_LOCK.
  - Transition: `timer`==DONE_TIMEOUT-1 → FAIL.
- **WAIT_LOCK [3]**
  - Transition: `block_lock` && !`high_ber` → DEBOUNCE.
  - Transition: `timer`==LOCK_TIMEOUT-1 → FAIL.
- **DEBOUNCE [4]**
  - Transition: lock lost or `high_ber` → WAIT_LOCK. Does not increment `retry`.
  - Transition: `timer`==UP_DEBOUNCE-1 → LINK_UP. Clears `retry`.
- **LINK_UP [5]**
  - Outputs: `link_up`=1.
  - Transition: lock lost, `high_ber` or `rx_done` low → RX_RESET. Increments `flap_count`.
- **FAIL (transient, 1 cycle, code 6)**
  - Increments `retry`.
  - Transition: if `retry`+1 ≥ MAX_RX_RETRIES → FULL_RESET, else → RX_RESET.
- **FULL_RESET [7]**
  - Outputs: `gt_reset_all`=1 for FULL_RESET_CYCLES.
  - Transition: then clear `retry` → WAIT_RX_DONE.

Global rules:
- `modprs_n`=1 in any state → NO_MODULE next cycle. This has priority over all other transitions. Leaving LINK_UP this way also increments `flap_count`.
- A full reset normally causes `gt_tx_reset` to assert and reset this block asynchronously. The FULL_RESET exit path covers the case where it does not.

## Timing
- Reset values (`gt_tx_reset` high): state=NO_MODULE, `rx_datapath_reset`=1, `gt_reset_all`=0, `link_up`=0, `link_state`=0, `flap_count`=0, `retry`=0, `timer`=0.
  - `gt_reset_all` resets to 0 so the block cannot deadlock the GT reset that gates it.
- Input-to-state latency: 2 synchronizer cycles + 1 state register cycle. Outputs update in the cycle the state register changes.
- Pulse widths are exact:
  - `rx_datapath_reset` is high for exactly RX_RESET_CYCLES per entry to RX_RESET.
  - `gt_reset_all` is high for exactly FULL_RESET_CYCLES per entry to FULL_RESET.
- `link_up` falls in the same cycle the FSM leaves LINK_UP.
- `flap_count` increments in the same cycle `link_up` falls.
- Reset mid-pulse: both pulses drop asynchronously and the FSM restarts in NO_MODULE.
- Simultaneous loss of lock and module removal in LINK_UP → NO_MODULE, `flap_count` +1 (a single increment).
- Timer width is $clog2 of the largest timeout; it never wraps inside a state.

## Test plan
- **Power-up:** hold reset 10 cycles, release with `modprs_n`=0, `rx_done`=1, `block_lock`=1.
  - Required: 32-cycle `rx_datapath_reset` pulse.
  - Required: `link_up` rises exactly 1024 cycles after DEBOUNCE entry; `link_state`=5.
- **Lock flap:** in LINK_UP, drop `block_lock` for 1 cycle.
  - Required: `link_up` falls 3 cycles later; `flap_count`=1; new 32-cycle RX reset.
- **Lock never arrives:** `block_lock`=0 with all other inputs healthy.
  - Required: 4 RX reset pulses spaced by LOCK_TIMEOUT.
  - Required: then `gt_reset_all` high for 256 cycles; `retry` cleared.
- **Debounce glitch:** assert `high_ber` at DEBOUNCE cycle 500.
  - Required: return to WAIT_LOCK; `link_up` stays 0; `retry` unchanged.
- **Module removal in LINK_UP:** `modprs_n`=1.
  - Required: NO_MODULE; `rx_datapath_reset` held at 1; `flap_count` +1.
  - On reinsertion: a fresh bring-up sequence runs.
- **Saturation and reset mid-pulse:**
  - Force 300 flaps → `flap_count`=255.
  - Assert `gt_tx_reset` during `gt_reset_all` → `gt_reset_all`=0 immediately; `flap_count`=0.

Source files
------------

// File: rtl/sfp_link_supervisor.sv
// -----------------------------------------------------------------------------
// sfp_link_supervisor
//
// Link bring-up and recovery controller for the 10G SFP port. Runs on the
// free-running 125 MHz clock. It watches GT RX reset-done, PCS block lock,
// PCS high-BER and SFP module presence. It sequences RX datapath resets and
// escalates to a full GT reset after repeated lock failures. It also publishes
// a debounced link-up flag, the FSM state code and a saturating flap counter.
//
// Ports
//   clk_125mhz_int    in   free-running clock
//   gt_tx_reset       in   asynchronous active-high reset
//   gt_reset_rx_done  in   async, RX reset done (RX user-clock domain)
//   rx_block_lock     in   async, PCS block lock
//   rx_high_ber       in   async, PCS high-BER indication
//   sfp_modprs_n      in   async, low = module present
//   rx_datapath_reset out  request to the GT RX datapath reset
//   gt_reset_all      out  request for a full GT reset
//   link_up           out  debounced link status
//   link_state        out  [2:0] current FSM state code
//   flap_count        out  [7:0] link-up -> link-down transitions, saturating
// -----------------------------------------------------------------------------
module sfp_link_supervisor #(
   parameter int unsigned RX_RESET_CYCLES   = 32,
   parameter int unsigned FULL_RESET_CYCLES = 256,
   parameter int unsigned LOCK_TIMEOUT      = 125000,
   parameter int unsigned DONE_TIMEOUT      = 250000,
   parameter int unsigned UP_DEBOUNCE       = 1024,
   parameter int unsigned MAX_RX_RETRIES    = 4
) (
   input  logic       clk_125mhz_int,
   input  logic       gt_tx_reset,
   input  logic       gt_reset_rx_done,
   input  logic       rx_block_lock,
   input  logic       rx_high_ber,
   input  logic       sfp_modprs_n,
   output logic       rx_datapath_reset,
   output logic       gt_reset_all,
   output logic       link_up,
   output logic [2:0] link_state,
   output logic [7:0] flap_count
);

   // State codes double as the published link_state value.
   localparam logic [2:0] ST_NO_MODULE    = 3'd0;
   localparam logic [2:0] ST_RX_RESET     = 3'd1;
   localparam logic [2:0] ST_WAIT_RX_DONE = 3'd2;
   localparam logic [2:0] ST_WAIT_LOCK    = 3'd3;
   localparam logic [2:0] ST_DEBOUNCE     = 3'd4;
   localparam logic [2:0] ST_LINK_UP      = 3'd5;
   localparam logic [2:0] ST_FAIL         = 3'd6;
   localparam logic [2:0] ST_FULL_RESET   = 3'd7;

   // Timer is sized for the longest interval any state has to measure.
   localparam int unsigned MAX_A   = (LOCK_TIMEOUT > DONE_TIMEOUT) ? LOCK_TIMEOUT : DONE_TIMEOUT;
   localparam int unsigned MAX_B   = (RX_RESET_CYCLES > FULL_RESET_CYCLES) ? RX_RESET_CYCLES : FULL_RESET_CYCLES;
   localparam int unsigned MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned T_MAX   = (MAX_C > UP_DEBOUNCE) ? MAX_C : UP_DEBOUNCE;
   localparam int unsigned TIMER_W = ($clog2(T_MAX) < 1) ? 1 : $clog2(T_MAX);

   localparam logic [TIMER_W-1:0] RX_LAST   = TIMER_W'(RX_RESET_CYCLES - 1);
   localparam logic [TIMER_W-1:0] FULL_LAST = TIMER_W'(FULL_RESET_CYCLES - 1);
   localparam logic [TIMER_W-1:0] LOCK_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
   localparam logic [TIMER_W-1:0] DONE_LAST = TIMER_W'(DONE_TIMEOUT - 1);
   localparam logic [TIMER_W-1:0] DEB_LAST  = TIMER_W'(UP_DEBOUNCE - 1);

   // -------------------------------------------------------------------------
   // Input synchronizers, bit order {modprs_n, high_ber, block_lock, rx_done}.
   // modprs_n resets to 1 so nothing advances until a real "present" is seen.
   // -------------------------------------------------------------------------
   localparam logic [3:0] SYNC_RESET = 4'b1000;

   logic [3:0] sync_in;
   logic [3:0] sync_meta;
   logic [3:0] sync_out;

   assign sync_in = {sfp_modprs_n, rx_high_ber, rx_block_lock, gt_reset_rx_done};

   always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
      if (gt_tx_reset) begin
         sync_meta <= SYNC_RESET;
         sync_out  <= SYNC_RESET;
      end else begin
         sync_meta <= sync_in;
         sync_out  <= sync_meta;
      end
   end

   logic modprs_n;
   logic high_ber;
   logic block_lock;
   logic rx_done;

   assign modprs_n   = sync_out[3];
   assign high_ber   = sync_out[2];
   assign block_lock = sync_out[1];
   assign rx_done    = sync_out[0];

   // -------------------------------------------------------------------------
   // FSM
   // -------------------------------------------------------------------------
   logic [2:0]         state;
   logic [2:0]         next_state;
   logic [TIMER_W-1:0] timer;
   logic [2:0]         retry;
   logic               lock_good;
   logic               escalate;
   logic               state_change;

   assign lock_good    = block_lock && !high_ber;
   assign escalate     = (32'(retry) + 32'd1) >= MAX_RX_RETRIES;
   assign state_change = (next_state != state);

   always_comb begin
      next_state = state;
      if (modprs_n) begin
         // Module absence overrides every other transition.
         next_state = ST_NO_MODULE;
      end else begin
         case (state)
            ST_NO_MODULE: next_state = ST_RX_RESET;
            ST_RX_RESET: begin
               if (timer == RX_LAST) next_state = ST_WAIT_RX_DONE;
            end
            ST_WAIT_RX_DONE: begin
               if (rx_done)                next_state = ST_WAIT_LOCK;
               else if (timer == DONE_LAST) next_state = ST_FAIL;
            end
            ST_WAIT_LOCK: begin
               if (lock_good)               next_state = ST_DEBOUNCE;
               else if (timer == LOCK_LAST) next_state = ST_FAIL;
            end
            ST_DEBOUNCE: begin
               if (!lock_good)             next_state = ST_WAIT_LOCK;
               else if (timer == DEB_LAST) next_state = ST_LINK_UP;
            end
            ST_LINK_UP: begin
               if (!lock_good || !rx_done) next_state = ST_RX_RESET;
            end
            ST_FAIL: begin
               next_state = escalate ? ST_FULL_RESET : ST_RX_RESET;
            end
            ST_FULL_RESET: begin
               if (timer == FULL_LAST) next_state = ST_WAIT_RX_DONE;
            end
            default: next_state = ST_NO_MODULE;
         endcase
      end
   end

   always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
      if (gt_tx_reset) begin
         state <= ST_NO_MODULE;
         timer <= '0;
      end else begin
         state <= next_state;
         // Cleared on every state entry; saturates so it never wraps in a state.
         if (state_change)    timer <= '0;
         else if (timer != '1) timer <= timer + 1'b1;
      end
   end

   always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
      if (gt_tx_reset) begin
         retry <= '0;
      end else if ((state == ST_DEBOUNCE && next_state == ST_LINK_UP) ||
                   (state == ST_FULL_RESET && next_state == ST_WAIT_RX_DONE)) begin
         retry <= '0;
      end else if (state == ST_FAIL && retry != '1) begin
         retry <= retry + 1'b1;
      end
   end

   // Any exit from LINK_UP (lock loss, rx_done loss or removal) is one flap.
   always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
      if (gt_tx_reset) begin
         flap_count <= '0;
      end else if (state == ST_LINK_UP && state_change && flap_count != '1) begin
         flap_count <= flap_count + 1'b1;
      end
   end

   // Outputs are registered from next_state so they change together with state.
   always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
      if (gt_tx_reset) begin
         rx_datapath_reset <= 1'b1;
         gt_reset_all      <= 1'b0;
         link_up           <= 1'b0;
         link_state        <= ST_NO_MODULE;
      end else begin
         rx_datapath_reset <= (next_state == ST_NO_MODULE) || (next_state == ST_RX_RESET);
         gt_reset_all      <= (next_state == ST_FULL_RESET);
         link_up           <= (next_state == ST_LINK_UP);
         link_state        <= next_state;
      end
   end

endmodule
